// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin arbitration in front of a single
// SETUP/ACCESS transfer engine with optional wait-state timeout.
module apb_req_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [1:0]  REQ,
    input  logic [63:0] REQ_ADDR,
    input  logic [1:0]  REQ_WRITE,
    input  logic [63:0] REQ_WDATA,
    input  logic [7:0]  REQ_SLOT,
    output logic [1:0]  ACK,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic        TOUT,
    output logic        BUSY,
    output logic [15:0] PSEL,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;

    localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];
    localparam bit         TimeoutEn  = (TIMEOUT != 0);

    logic [1:0]  state_q;
    logic        last_q;
    logic        gnt_q;
    logic [3:0]  slot_q;
    logic [7:0]  wait_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        pwrite_q;
    logic [31:0] rdata_q;
    logic [1:0]  ack_q;
    logic        err_q;
    logic        tout_q;

    logic [1:0]  req_eff;
    logic        grant_valid;
    logic        grant_idx;
    logic        timeout_hit;

    // A requester being acknowledged this cycle sits out one arbitration round.
    always_comb begin
        req_eff     = REQ & ~ack_q;
        grant_valid = |req_eff;
        grant_idx   = (req_eff == 2'b11) ? ~last_q : req_eff[1];
        timeout_hit = TimeoutEn && (wait_q == TimeoutCnt);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            slot_q   <= 4'd0;
            wait_q   <= 8'd0;
            paddr_q  <= 32'd0;
            pwdata_q <= 32'd0;
            pwrite_q <= 1'b0;
            rdata_q  <= 32'd0;
            ack_q    <= 2'b00;
            err_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            ack_q  <= 2'b00;
            err_q  <= 1'b0;
            tout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        gnt_q    <= grant_idx;
                        last_q   <= grant_idx;
                        paddr_q  <= grant_idx ? REQ_ADDR[63:32]  : REQ_ADDR[31:0];
                        pwdata_q <= grant_idx ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
                        slot_q   <= grant_idx ? REQ_SLOT[7:4]    : REQ_SLOT[3:0];
                        pwrite_q <= REQ_WRITE[grant_idx];
                        wait_q   <= 8'd0;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                end
                StAccess: begin
                    if (PREADY) begin
                        ack_q   <= gnt_q ? 2'b10 : 2'b01;
                        err_q   <= PSLVERR;
                        if (!pwrite_q) begin
                            rdata_q <= PRDATA;
                        end
                        state_q <= StIdle;
                    end else if (timeout_hit) begin
                        ack_q   <= gnt_q ? 2'b10 : 2'b01;
                        err_q   <= 1'b1;
                        tout_q  <= 1'b1;
                        rdata_q <= 32'd0;
                        state_q <= StIdle;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        PSEL = 16'd0;
        if (state_q != StIdle) begin
            PSEL[slot_q] = 1'b1;
        end
    end

    assign PENABLE = (state_q == StAccess);
    assign BUSY    = (state_q != StIdle);
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign ACK     = ack_q;
    assign RDATA   = rdata_q;
    assign ERR     = err_q;
    assign TOUT    = tout_q;

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum ACCESS wait cycles with PREADY low before forced termination; 0 disables the timeout.
REQ-002 PCLK  in  1  sole clock; all state changes on rising edge.
REQ-003 PRESET  in  1  reset, synchronous, active-high.
REQ-004 REQ  in  2  per-requester transfer request; bit i = requester i.
REQ-005 REQ_ADDR  in  64  {addr1,addr0}, 32 bits per requester.
REQ_WRITE  in  2  1 = write, 0 = read, per requester.
REQ_WDATA  in  64  {wdata1,wdata0}.
REQ_SLOT  in  8  {slot1,slot0}, 4-bit target PSEL index per requester.
REQ-006 ACK  out  2  one-cycle completion pulse, bit i = requester i.
RDATA  out  32  read data, valid with ACK.
ERR  out  1  error flag, valid with ACK.
TOUT  out  1  timeout flag, valid with ACK.
BUSY  out  1  high while not IDLE.
REQ-007 PSEL  out  16  one-hot slave select.
PADDR  out  32  APB address.
PWRITE  out  1  APB direction.
PENABLE  out  1  APB enable.
PWDATA  out  32  APB write data.
PRDATA  in  32  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB slave error.

Function
REQ-008 FSM states: IDLE, SETUP, ACCESS; one transfer in flight at most.
REQ-009 IDLE: if any unmasked REQ bit high, grant one, latch its ADDR/WRITE/WDATA/SLOT, go to SETUP next cycle; else stay.
REQ-010 Arbitration is round-robin. Pointer LAST holds the last granted index. On simultaneous requests, grant the index not equal to LAST. A single request always wins. LAST updates on grant.
REQ-011 SETUP (1 cycle): PSEL[slot]=1, other PSEL bits 0, PENABLE=0, PADDR/PWRITE/PWDATA from latched values; go to ACCESS.
REQ-012 ACCESS: PSEL unchanged, PENABLE=1. If PREADY=1, complete and go to IDLE. If PREADY=0, stay and increment the 8-bit wait counter (cleared on entry to SETUP).
REQ-013 Completion registers for exactly one cycle, the first IDLE cycle: ACK[granted]=1, ERR=PSLVERR sampled with PREADY, TOUT=0. For a read, RDATA=PRDATA sampled with PREADY. For a write, RDATA holds its previous value.
REQ-014 Timeout: if TIMEOUT != 0 and the wait counter equals TIMEOUT while PREADY=0 in ACCESS, terminate and go to IDLE. Next cycle: ACK[granted]=1, ERR=1, TOUT=1, RDATA=0.
REQ-015 In IDLE, PSEL=0 and PENABLE=0. PADDR, PWRITE and PWDATA hold their last values.
REQ-016 In the cycle ACK[i]=1, REQ[i] is masked from arbitration. This gives one idle cycle minimum between transfers of the same requester. The other requester may be granted in that cycle (back-to-back).
REQ-017 REQ_* inputs are ignored after the grant. Deasserting REQ[i] before ACK does not abort the transfer; ACK still issues.
REQ-018 BUSY=1 in SETUP and ACCESS, 0 in IDLE.
REQ-019 REQ, PREADY and PSLVERR are sampled only in the states above; X or changes elsewhere have no effect.

Reset
REQ-020 With PRESET=1 at a rising edge, next cycle: state=IDLE, LAST=1, wait counter=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, ACK=0, RDATA=0, ERR=0, TOUT=0, BUSY=0.
REQ-021 PRESET during SETUP or ACCESS abandons the transfer: no ACK, and the APB outputs are reset as in REQ-020.
REQ-022 PRESET has priority over every other event in the same cycle.

Verification
REQ-023 Single write: REQ=01, addr0=0x40, wdata0=0xA5A5_0001, slot0=3, PREADY=1 -> PSEL=0x0008 at T+1, PENABLE at T+2, ACK=01 with ERR=0 at T+3.
REQ-024 Simultaneous: REQ=11 held, both reads, PREADY=1 -> grant order 0,1,0,1. ACKs alternate 01,10, each transfer 3 cycles (back-to-back via REQ-016).
REQ-025 Wait states: read with PREADY low 4 cycles then high with PRDATA=0x1234_5678, PSLVERR=1 -> ACCESS lasts 5 cycles; ACK with RDATA=0x1234_5678, ERR=1, TOUT=0.
REQ-026 Timeout: TIMEOUT=4, PREADY held low -> PENABLE drops after 5 ACCESS cycles; ACK with ERR=1, TOUT=1, RDATA=0. TIMEOUT=0 -> stalls indefinitely.
REQ-027 Reset mid-ACCESS: PRESET=1 for 1 cycle while PENABLE=1 -> next cycle all outputs 0, no ACK, BUSY=0. With REQ=11 afterwards, requester 0 is granted first.
